// File: rtl/bf_radix2_pipe.sv
// Three-stage pipelined radix-2 FFT butterfly (DIF or DIT selected by MODE) with per-sample
// /2 scaling, output saturation, sticky overflow and valid/ready flow control under a global stall.
module bf_radix2_pipe #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 8,
    parameter int MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              scale,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [TW_W-1:0]   w_re,
    input  logic [TW_W-1:0]   w_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y0_re,
    output logic [DATA_W-1:0] y0_im,
    output logic [DATA_W-1:0] y1_re,
    output logic [DATA_W-1:0] y1_im,
    output logic              ovf
);
    localparam int EW = DATA_W + 1;
    localparam int PW = EW + TW_W + 1;
    localparam logic signed [PW-1:0] RHALF = PW'(2 ** (TW_FRAC - 1));
    localparam logic signed [PW-1:0] DMAX  = PW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PW-1:0] EMAX  = PW'(2 ** DATA_W - 1);

    if (FRAC_W < 0 || FRAC_W >= DATA_W || TW_FRAC < 1 || TW_FRAC >= TW_W ||
        MODE < 0 || MODE > 1) begin : g_param_check
        $error("bf_radix2_pipe: unsupported parameter set");
    end

    function automatic logic signed [PW-1:0] round_tw(input logic signed [PW-1:0] p);
        return (p + RHALF) >>> TW_FRAC;
    endfunction

    function automatic logic signed [PW-1:0] clamp(input logic signed [PW-1:0] x,
                                                   input logic signed [PW-1:0] hi,
                                                   output logic hit);
        hit = 1'b1;
        if (x > hi) return hi;
        if (x < -hi - PW'(1)) return -hi - PW'(1);
        hit = 1'b0;
        return x;
    endfunction

    function automatic logic signed [PW-1:0] halve(input logic signed [PW-1:0] x,
                                                   input logic en);
        return en ? (x + PW'(1)) >>> 1 : x;
    endfunction

    function automatic logic [DATA_W-1:0] sat_out(input logic signed [PW-1:0] x,
                                                  output logic hit);
        hit = 1'b1;
        if (x > DMAX) return DMAX[DATA_W-1:0];
        if (x < -DMAX - PW'(1)) return ~DMAX[DATA_W-1:0];
        hit = 1'b0;
        return x[DATA_W-1:0];
    endfunction

    logic adv;
    logic take;
    logic v1, v2;
    logic sc1, sc2;
    logic signed [PW-1:0] q0_re, q0_im, q1_re, q1_im;
    logic q_clip;

    // Global stall: every stage holds whenever the output register is full and not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            sc1 <= 1'b0;
            sc2 <= 1'b0;
        end else if (adv) begin
            v1  <= take;
            v2  <= v1;
            sc1 <= scale;
            sc2 <= sc1;
        end
    end

    if (MODE == 0) begin : g_dif
        logic signed [EW-1:0]   s1_re, s1_im, d1_re, d1_im;
        logic signed [EW-1:0]   s2_re, s2_im;
        logic signed [TW_W-1:0] w1_re, w1_im;
        logic signed [PW-1:0]   m2_re, m2_im;

        always_ff @(posedge clk) begin
            if (adv) begin
                s1_re <= EW'($signed(a_re)) + EW'($signed(b_re));
                s1_im <= EW'($signed(a_im)) + EW'($signed(b_im));
                d1_re <= EW'($signed(a_re)) - EW'($signed(b_re));
                d1_im <= EW'($signed(a_im)) - EW'($signed(b_im));
                w1_re <= $signed(w_re);
                w1_im <= $signed(w_im);
                s2_re <= s1_re;
                s2_im <= s1_im;
                m2_re <= PW'(d1_re) * PW'(w1_re) - PW'(d1_im) * PW'(w1_im);
                m2_im <= PW'(d1_re) * PW'(w1_im) + PW'(d1_im) * PW'(w1_re);
            end
        end

        assign q0_re  = PW'(s2_re);
        assign q0_im  = PW'(s2_im);
        assign q1_re  = round_tw(m2_re);
        assign q1_im  = round_tw(m2_im);
        assign q_clip = 1'b0;
    end else begin : g_dit
        logic signed [DATA_W-1:0] a1_re, a1_im;
        logic signed [PW-1:0]     p1_re, p1_im;
        logic signed [PW-1:0]     bw_re, bw_im;
        logic signed [PW-1:0]     s2_re, s2_im, d2_re, d2_im;
        logic                     hit_re, hit_im;
        logic                     c2;

        // B*W is brought back to DATA_W+1 bits before the add/sub; a clip here is also an overflow.
        always_comb begin
            bw_re = clamp(round_tw(p1_re), EMAX, hit_re);
            bw_im = clamp(round_tw(p1_im), EMAX, hit_im);
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                a1_re <= $signed(a_re);
                a1_im <= $signed(a_im);
                p1_re <= PW'($signed(b_re)) * PW'($signed(w_re)) -
                         PW'($signed(b_im)) * PW'($signed(w_im));
                p1_im <= PW'($signed(b_re)) * PW'($signed(w_im)) +
                         PW'($signed(b_im)) * PW'($signed(w_re));
                s2_re <= PW'(a1_re) + bw_re;
                s2_im <= PW'(a1_im) + bw_im;
                d2_re <= PW'(a1_re) - bw_re;
                d2_im <= PW'(a1_im) - bw_im;
                c2    <= hit_re || hit_im;
            end
        end

        assign q0_re  = s2_re;
        assign q0_im  = s2_im;
        assign q1_re  = d2_re;
        assign q1_im  = d2_im;
        assign q_clip = c2;
    end

    logic [DATA_W-1:0] f0_re, f0_im, f1_re, f1_im;
    logic h0_re, h0_im, h1_re, h1_im;

    always_comb begin
        f0_re = sat_out(halve(q0_re, sc2), h0_re);
        f0_im = sat_out(halve(q0_im, sc2), h0_im);
        f1_re = sat_out(halve(q1_re, sc2), h1_re);
        f1_im = sat_out(halve(q1_im, sc2), h1_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            y0_re     <= '0;
            y0_im     <= '0;
            y1_re     <= '0;
            y1_im     <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                y0_re <= f0_re;
                y0_im <= f0_im;
                y1_re <= f1_re;
                y1_im <= f1_im;
                ovf   <= ovf || q_clip || h0_re || h0_im || h1_re || h1_im;
            end
        end
    end
endmodule
